// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq
//
// Replays the knight's-tour solver's move list as motion commands. Each
// one-hot move becomes two commands: a vertical leg (opcode 2) followed by
// a horizontal leg with fanfare (opcode 3). Outside a tour the block is a
// transparent combinational pass-through for UART-sourced commands.
//
// Handshake: cmd is valid while cmd_rdy is high. The consumer takes it by
// pulsing clr_cmd_rdy, which drops cmd_rdy after that edge. The consumer
// later pulses send_resp once the command has finished executing.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start_tour        pulse, begins a replay (honoured only in IDLE)
//   move[7:0]         one-hot move for the current mv_indx
//   mv_indx[4:0]      registered index into the solver move list
//   cmd_UART[15:0]    UART command, passed through in IDLE
//   cmd_rdy_UART      UART command valid
//   clr_cmd_rdy_UART  acknowledge to the UART wrapper (IDLE only)
//   cmd[15:0]         command to the command processor
//   cmd_rdy           cmd valid
//   clr_cmd_rdy       command processor has taken cmd
//   send_resp         command processor has finished the command
//   resp[7:0]         response byte to the host
//   tour_err          sticky, set when a zero move aborted the tour
//   dbg_state[2:0]    current FSM state, for observation only
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_err,
  output logic [2:0]  dbg_state
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    VERT   = 3'd2,
    WAIT_V = 3'd3,
    HORZ   = 3'd4,
    WAIT_H = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx_q, idx_nxt;
  logic [15:0] cmd_q, cmd_nxt;
  logic        rdy_q, rdy_nxt;
  logic        err_q, err_nxt;
  logic [7:0]  move_q, move_nxt;

  // Returns {dx, dy} as two 3-bit signed values. The lowest set bit wins
  // when the solver hands over more than one bit.
  function automatic logic [5:0] decode(input logic [7:0] m);
    logic signed [2:0] dx, dy;
    dx = 3'sd0;
    dy = 3'sd0;
    if      (m[0]) begin dx =  3'sd1; dy =  3'sd2; end
    else if (m[1]) begin dx = -3'sd1; dy =  3'sd2; end
    else if (m[2]) begin dx = -3'sd2; dy =  3'sd1; end
    else if (m[3]) begin dx = -3'sd2; dy = -3'sd1; end
    else if (m[4]) begin dx = -3'sd1; dy = -3'sd2; end
    else if (m[5]) begin dx =  3'sd1; dy = -3'sd2; end
    else if (m[6]) begin dx =  3'sd2; dy = -3'sd1; end
    else if (m[7]) begin dx =  3'sd2; dy =  3'sd1; end
    return {dx, dy};
  endfunction

  function automatic logic [3:0] mag(input logic [2:0] v);
    logic [2:0] a;
    a = v[2] ? (~v + 3'd1) : v;
    return {1'b0, a};
  endfunction

  function automatic logic [15:0] vert_leg(input logic [7:0] m);
    logic [5:0] d;
    logic [2:0] dy;
    d  = decode(m);
    dy = d[2:0];
    return {4'h2, (dy[2] ? HEAD_S : HEAD_N), mag(dy)};
  endfunction

  function automatic logic [15:0] horz_leg(input logic [7:0] m);
    logic [5:0] d;
    logic [2:0] dx;
    d  = decode(m);
    dx = d[5:3];
    return {4'h3, (dx[2] ? HEAD_W : HEAD_E), mag(dx)};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx_q  <= 5'd0;
      cmd_q  <= 16'h0000;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      move_q <= 8'h00;
    end else begin
      state  <= state_nxt;
      idx_q  <= idx_nxt;
      cmd_q  <= cmd_nxt;
      rdy_q  <= rdy_nxt;
      err_q  <= err_nxt;
      move_q <= move_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    cmd_nxt   = cmd_q;
    rdy_nxt   = rdy_q;
    err_nxt   = err_q;
    move_nxt  = move_q;
    case (state)
      IDLE: begin
        if (start_tour) begin
          state_nxt = FETCH;
          idx_nxt   = 5'd0;
          err_nxt   = 1'b0;
        end
      end
      // move settles during this cycle and is sampled on the exit edge.
      FETCH: begin
        if (move == 8'h00) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = VERT;
          move_nxt  = move;
          cmd_nxt   = vert_leg(move);
          rdy_nxt   = 1'b1;
        end
      end
      // send_resp here is meaningless (nothing taken yet) and is dropped.
      VERT: begin
        if (clr_cmd_rdy) begin
          state_nxt = WAIT_V;
          rdy_nxt   = 1'b0;
        end
      end
      WAIT_V: begin
        if (send_resp) begin
          state_nxt = HORZ;
          cmd_nxt   = horz_leg(move_q);
          rdy_nxt   = 1'b1;
        end
      end
      HORZ: begin
        if (clr_cmd_rdy) begin
          state_nxt = WAIT_H;
          rdy_nxt   = 1'b0;
        end
      end
      WAIT_H: begin
        if (send_resp) begin
          if (idx_q == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = FETCH;
            idx_nxt   = idx_q + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // UART commands reach the processor only in IDLE; elsewhere they stall.
  always_comb begin
    if (state == IDLE) begin
      cmd              = cmd_UART;
      cmd_rdy          = cmd_rdy_UART;
      clr_cmd_rdy_UART = clr_cmd_rdy;
    end else begin
      cmd              = cmd_q;
      cmd_rdy          = rdy_q;
      clr_cmd_rdy_UART = 1'b0;
    end
  end

  assign resp = ((state == IDLE) || ((state == WAIT_H) && (idx_q == LAST_IDX)))
                ? 8'hA5 : 8'h5A;

  assign mv_indx   = idx_q;
  assign tour_err  = err_q;
  assign dbg_state = state;

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Downstream consumer of the knight's-tour solver: after the solver asserts done, this block walks the stored move list by driving `mv_indx` and reading back the one-hot `move`. It turns each knight move into two motion commands for the command processor: a vertical leg, then a horizontal leg with fanfare. Outside a tour it is a transparent pass-through for UART-sourced commands. It owns the `cmd`/`cmd_rdy` handshake and the `resp` byte returned to the host.

## Interface
- NUM_MOVES, 24, moves replayed per tour (5x5 board); final index is NUM_MOVES-1
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start_tour  in  1  one-cycle pulse; begins replay, honoured only in IDLE
- move  in  8  one-hot move from solver for current `mv_indx`; valid one cycle after `mv_indx` changes
- mv_indx  out  5  registered index into solver move list
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  acknowledge to UART wrapper
- cmd  out  16  command to command processor
- cmd_rdy  out  1  `cmd` valid
- clr_cmd_rdy  in  1  command processor has taken `cmd`
- send_resp  in  1  command processor finished executing the command
- resp  out  8  response byte to host
- tour_err  out  1  sticky: a non-one-hot move (zero) aborted the tour

## Operation
- Command word: [15:12] opcode, [11:4] heading, [3:0] squares. Opcode 4'h2 = move, 4'h3 = move with fanfare.
- Headings: N 8'h00, W 8'h3F, S 8'h7F, E 8'hBF.
- Move decode as (dx,dy):
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- Vertical leg = {4'h2, N if dy>0 else S, |dy|}. Horizontal leg = {4'h3, E if dx>0 else W, |dx|}.
- If more than one bit is set, the lowest set bit wins. move==0 sets tour_err and returns to IDLE.
- States:
  - IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy (combinational mux). start_tour -> FETCH, mv_indx<=0, tour_err<=0.
  - FETCH: one cycle for `move` to settle -> VERT. On exit, latch move, load cmd with vertical leg, set cmd_rdy. If move==0 -> IDLE with tour_err<=1.
  - VERT: hold cmd_rdy until clr_cmd_rdy; then cmd_rdy<=0 -> WAIT_V.
  - WAIT_V: on send_resp, load horizontal leg, cmd_rdy<=1 -> HORZ.
  - HORZ: on clr_cmd_rdy, cmd_rdy<=0 -> WAIT_H.
  - WAIT_H: on send_resp, if mv_indx==NUM_MOVES-1 -> IDLE; else mv_indx<=mv_indx+1 -> FETCH.
- Outside IDLE: clr_cmd_rdy_UART=0, and cmd_rdy_UART is ignored (UART commands stall).
- resp = 8'hA5 in IDLE, and in WAIT_H when mv_indx==NUM_MOVES-1 (tour complete). Otherwise resp = 8'h5A (intermediate acknowledgement).
- start_tour outside IDLE is ignored.

## Timing
- Reset values: state IDLE, mv_indx 0, tour-side cmd register 16'h0000, cmd_rdy register 0, tour_err 0. Visible outputs after reset follow the IDLE mux; resp=8'hA5.
- rst dominates every input on the same edge. Reset mid-tour returns to IDLE next edge and drops tour cmd_rdy; no partial leg is reissued.
- Latency: start_tour at edge N -> FETCH at N+1 -> VERT with cmd_rdy=1 and valid cmd at N+2.
- clr_cmd_rdy at edge M -> cmd_rdy low after M.
- send_resp in WAIT_V at edge K -> HORZ with cmd_rdy=1 after K.
- send_resp in WAIT_H at K -> next FETCH after K, next vertical cmd_rdy after K+1.
- clr_cmd_rdy and send_resp asserted in the same cycle in VERT: only clr_cmd_rdy acts; send_resp is dropped.
- mv_indx never exceeds NUM_MOVES-1 and does not wrap.

## Test plan
- Reset, then cmd_UART=16'h2BF3, cmd_rdy_UART=1 -> cmd=16'h2BF3, cmd_rdy=1, resp=8'hA5; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1 same cycle.
- start_tour with move=8'h01 at index 0 -> two cycles later cmd=16'h2002, cmd_rdy=1. After clr_cmd_rdy then send_resp -> cmd=16'h3BF1, resp=8'h5A during the send_resp cycle.
- move=8'h08 -> vertical 16'h27F1, horizontal 16'h33F2. move=8'h80 -> 16'h2001 then 16'h3BF2.
- Full 24-move replay with a scripted move list and auto-acknowledging processor model: 48 commands in order, mv_indx steps 0..23, final send_resp sees resp=8'hA5, state returns to IDLE.
- move=8'h00 at index 5 -> tour_err=1, return to IDLE, no cmd_rdy issued; next start_tour clears tour_err.
- rst asserted in WAIT_V at index 10 -> next cycle mv_indx=0, cmd_rdy follows cmd_rdy_UART. start_tour in HORZ -> no effect.
